// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage
// Registered pipeline-stage boundary with a valid/ready handshake and a
// two-entry skid buffer. Every output is driven straight from a flop:
// out_* from the main register, and in_ready/occupancy from the state flops.
// A synchronous flush turns the stage back into bubbles. The control field
// of any empty slot is held at BUBBLE_CTRL.

module mem_wb_pipe_stage #(
    parameter int                 CTRL_W      = 6,
    parameter int                 DATA_W      = 32,
    parameter int                 NDATA       = 3,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [NDATA*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [NDATA*DATA_W-1:0]   out_data,
    output logic [1:0]                occupancy
);

    localparam int LANES_W = NDATA * DATA_W;

    // State encoding is chosen so that bit 0 is main_valid and bit 1 is
    // skid_valid. The handshake outputs are then plain flop bits, and no
    // decode logic sits between out_ready/flush and in_ready.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [CTRL_W-1:0]    main_ctrl_q;
    logic [CTRL_W-1:0]    main_ctrl_d;
    logic [LANES_W-1:0]   main_data_q;
    logic [LANES_W-1:0]   main_data_d;

    logic [CTRL_W-1:0]    skid_ctrl_q;
    logic [CTRL_W-1:0]    skid_ctrl_d;
    logic [LANES_W-1:0]   skid_data_q;
    logic [LANES_W-1:0]   skid_data_d;

    logic                 main_valid;
    logic                 skid_valid;
    logic                 accept;
    logic                 pop;

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];

    // The skid slot is the only thing that can refuse a beat.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = main_valid & out_ready;

    // Next-state and datapath selection. Any slot that goes empty gets its
    // control field scrubbed to BUBBLE_CTRL. Data lanes keep their old
    // contents because only the control field matters downstream.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // A pop in this cycle still counts as consumed. An offered beat is dropped.
            state_d     = ST_EMPTY;
            main_ctrl_d = BUBBLE_CTRL;
            skid_ctrl_d = BUBBLE_CTRL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the newcomer behind main.
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (pop) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = BUBBLE_CTRL;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so the only event is a pop.
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = BUBBLE_CTRL;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = BUBBLE_CTRL;
                    skid_ctrl_d = BUBBLE_CTRL;
                end
            endcase
        end
    end

    // State and storage registers. Reset discards every held beat at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= BUBBLE_CTRL;
            main_data_q <= '0;
            skid_ctrl_q <= BUBBLE_CTRL;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Directed testbench for mem_wb_pipe_stage. The bench builds four instances
// and drives them all with the same handshake stimulus:
//   d0 uses the default parameters.
//   d1 uses BUBBLE_CTRL = 6'b000001.
//   d2 uses NDATA=1 and DATA_W=8.
//   d3 uses NDATA=4 and DATA_W=64.
// The bench drives inputs and samples outputs 1 time unit after each rising edge.

module tb_mem_wb_pipe_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [5:0]   in_ctrl;
    logic [255:0] in_data_w;

    logic         d0_in_ready, d0_out_valid;
    logic [5:0]   d0_out_ctrl;
    logic [95:0]  d0_out_data;
    logic [1:0]   d0_occ;

    logic         d1_in_ready, d1_out_valid;
    logic [5:0]   d1_out_ctrl;
    logic [95:0]  d1_out_data;
    logic [1:0]   d1_occ;

    logic         d2_in_ready, d2_out_valid;
    logic [5:0]   d2_out_ctrl;
    logic [7:0]   d2_out_data;
    logic [1:0]   d2_occ;

    logic         d3_in_ready, d3_out_valid;
    logic [5:0]   d3_out_ctrl;
    logic [255:0] d3_out_data;
    logic [1:0]   d3_occ;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_stage #(.CTRL_W(6), .DATA_W(32), .NDATA(3), .BUBBLE_CTRL(6'b000000)) d0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d0_in_ready), .in_ctrl(in_ctrl), .in_data(in_data_w[95:0]),
        .out_valid(d0_out_valid), .out_ready(out_ready), .out_ctrl(d0_out_ctrl), .out_data(d0_out_data),
        .occupancy(d0_occ)
    );

    mem_wb_pipe_stage #(.CTRL_W(6), .DATA_W(32), .NDATA(3), .BUBBLE_CTRL(6'b000001)) d1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d1_in_ready), .in_ctrl(in_ctrl), .in_data(in_data_w[95:0]),
        .out_valid(d1_out_valid), .out_ready(out_ready), .out_ctrl(d1_out_ctrl), .out_data(d1_out_data),
        .occupancy(d1_occ)
    );

    mem_wb_pipe_stage #(.CTRL_W(6), .DATA_W(8), .NDATA(1), .BUBBLE_CTRL(6'b000000)) d2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d2_in_ready), .in_ctrl(in_ctrl), .in_data(in_data_w[7:0]),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_ctrl(d2_out_ctrl), .out_data(d2_out_data),
        .occupancy(d2_occ)
    );

    mem_wb_pipe_stage #(.CTRL_W(6), .DATA_W(64), .NDATA(4), .BUBBLE_CTRL(6'b000000)) d3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d3_in_ready), .in_ctrl(in_ctrl), .in_data(in_data_w),
        .out_valid(d3_out_valid), .out_ready(out_ready), .out_ctrl(d3_out_ctrl), .out_data(d3_out_data),
        .occupancy(d3_occ)
    );

    // Advance to just past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat with lane 0 = d and all other lanes zero.
    task automatic offer(input logic v, input logic [5:0] c, input logic [31:0] d);
        in_valid  = v;
        in_ctrl   = c;
        in_data_w = {224'd0, d};
        if (v) $display("[TB] offer ctrl=%02h lane0=%08h flush=%0b out_ready=%0b", c, d, flush, out_ready);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 6'h00, 32'h0);
        step(); step();
        tests_run++; if (d0_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", d0_out_valid); end
        tests_run++; if (d0_out_ctrl !== 6'h00) begin tests_failed++; $display("FAIL reset_out_ctrl: got %02h want 00", d0_out_ctrl); end
        tests_run++; if (d0_out_data !== 96'd0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", d0_out_data); end
        tests_run++; if (d0_occ !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d want 0", d0_occ); end
        tests_run++; if (d0_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", d0_in_ready); end
        tests_run++; if (d1_out_ctrl !== 6'b000001) begin tests_failed++; $display("FAIL reset_bubble_ctrl: got %06b want 000001", d1_out_ctrl); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        offer(1'b1, 6'h21, 32'h1); step();
        tests_run++; if (d0_out_valid !== 1'b1 || d0_out_data[31:0] !== 32'h1 || d0_out_ctrl !== 6'h21)
            begin tests_failed++; $display("FAIL stream_beat1: got v=%0b ctrl=%02h d=%h want v=1 ctrl=21 d=1", d0_out_valid, d0_out_ctrl, d0_out_data[31:0]); end
        offer(1'b1, 6'h22, 32'h2); step();
        tests_run++; if (d0_out_valid !== 1'b1 || d0_out_data[31:0] !== 32'h2 || d0_out_ctrl !== 6'h22)
            begin tests_failed++; $display("FAIL stream_beat2: got v=%0b ctrl=%02h d=%h want v=1 ctrl=22 d=2", d0_out_valid, d0_out_ctrl, d0_out_data[31:0]); end
        tests_run++; if (d0_in_ready !== 1'b1 || d0_occ !== 2'd1)
            begin tests_failed++; $display("FAIL stream_ready: got rdy=%0b occ=%0d want rdy=1 occ=1", d0_in_ready, d0_occ); end
        offer(1'b1, 6'h23, 32'h3); step();
        tests_run++; if (d0_out_valid !== 1'b1 || d0_out_data[31:0] !== 32'h3 || d0_out_ctrl !== 6'h23)
            begin tests_failed++; $display("FAIL stream_beat3: got v=%0b ctrl=%02h d=%h want v=1 ctrl=23 d=3", d0_out_valid, d0_out_ctrl, d0_out_data[31:0]); end
        offer(1'b0, 6'h00, 32'h0); step();
        tests_run++; if (d0_out_valid !== 1'b0 || d0_out_ctrl !== 6'h00 || d0_occ !== 2'd0)
            begin tests_failed++; $display("FAIL stream_drain: got v=%0b ctrl=%02h occ=%0d want v=0 ctrl=00 occ=0", d0_out_valid, d0_out_ctrl, d0_occ); end
        tests_run++; if (d0_out_data[31:0] !== 32'h3)
            begin tests_failed++; $display("FAIL stream_data_hold: got %h want 3", d0_out_data[31:0]); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(1'b1, 6'h0A, 32'hA); step();
        tests_run++; if (d0_occ !== 2'd1 || d0_out_data[31:0] !== 32'hA)
            begin tests_failed++; $display("FAIL bp_hold_a: got occ=%0d d=%h want occ=1 d=a", d0_occ, d0_out_data[31:0]); end
        offer(1'b1, 6'h0B, 32'hB); step();
        tests_run++; if (d0_occ !== 2'd2 || d0_in_ready !== 1'b0 || d0_out_data[31:0] !== 32'hA)
            begin tests_failed++; $display("FAIL bp_skid_b: got occ=%0d rdy=%0b d=%h want occ=2 rdy=0 d=a", d0_occ, d0_in_ready, d0_out_data[31:0]); end
        offer(1'b1, 6'h0C, 32'hC); step();
        tests_run++; if (d0_occ !== 2'd2 || d0_in_ready !== 1'b0 || d0_out_ctrl !== 6'h0A)
            begin tests_failed++; $display("FAIL bp_refuse_c: got occ=%0d rdy=%0b ctrl=%02h want occ=2 rdy=0 ctrl=0a", d0_occ, d0_in_ready, d0_out_ctrl); end
        out_ready = 1'b1; step();
        tests_run++; if (d0_out_data[31:0] !== 32'hB || d0_out_ctrl !== 6'h0B || d0_occ !== 2'd1 || d0_in_ready !== 1'b1)
            begin tests_failed++; $display("FAIL bp_pop_b: got d=%h ctrl=%02h occ=%0d rdy=%0b want d=b ctrl=0b occ=1 rdy=1", d0_out_data[31:0], d0_out_ctrl, d0_occ, d0_in_ready); end
        step();
        tests_run++; if (d0_out_data[31:0] !== 32'hC || d0_out_ctrl !== 6'h0C || d0_out_valid !== 1'b1)
            begin tests_failed++; $display("FAIL bp_pop_c: got d=%h ctrl=%02h v=%0b want d=c ctrl=0c v=1", d0_out_data[31:0], d0_out_ctrl, d0_out_valid); end
        offer(1'b0, 6'h00, 32'h0); step();
        tests_run++; if (d0_out_valid !== 1'b0 || d0_occ !== 2'd0)
            begin tests_failed++; $display("FAIL bp_no_dup: got v=%0b occ=%0d want v=0 occ=0", d0_out_valid, d0_occ); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(1'b1, 6'h31, 32'h31); step();
        offer(1'b1, 6'h32, 32'h32); step();
        tests_run++; if (d0_occ !== 2'd2)
            begin tests_failed++; $display("FAIL flush_fill: got occ=%0d want 2", d0_occ); end
        flush = 1'b1;
        offer(1'b1, 6'h33, 32'h33); step();
        flush = 1'b0;
        offer(1'b0, 6'h00, 32'h0);
        tests_run++; if (d0_occ !== 2'd0 || d0_out_valid !== 1'b0 || d0_out_ctrl !== 6'h00 || d0_in_ready !== 1'b1)
            begin tests_failed++; $display("FAIL flush_two: got occ=%0d v=%0b ctrl=%02h rdy=%0b want 0 0 00 1", d0_occ, d0_out_valid, d0_out_ctrl, d0_in_ready); end
        tests_run++; if (d1_out_ctrl !== 6'b000001)
            begin tests_failed++; $display("FAIL flush_bubble_ctrl: got %06b want 000001", d1_out_ctrl); end
        out_ready = 1'b1; step();
        tests_run++; if (d0_out_valid !== 1'b0)
            begin tests_failed++; $display("FAIL flush_no_ghost: got v=%0b want 0", d0_out_valid); end
        // Flush while EMPTY with a beat on offer: the beat must be dropped.
        flush = 1'b1;
        offer(1'b1, 6'h34, 32'h34); step();
        flush = 1'b0;
        offer(1'b0, 6'h00, 32'h0);
        tests_run++; if (d0_out_valid !== 1'b0 || d0_occ !== 2'd0)
            begin tests_failed++; $display("FAIL flush_empty_drop: got v=%0b occ=%0d want 0 0", d0_out_valid, d0_occ); end
        step();
    endtask

    task automatic test_bubble_ctrl();
        out_ready = 1'b1;
        offer(1'b1, 6'h3E, 32'hBEEF); step();
        tests_run++; if (d1_out_valid !== 1'b1 || d1_out_ctrl !== 6'h3E)
            begin tests_failed++; $display("FAIL bubble_live: got v=%0b ctrl=%02h want v=1 ctrl=3e", d1_out_valid, d1_out_ctrl); end
        offer(1'b0, 6'h00, 32'h0); step();
        tests_run++; if (d1_out_valid !== 1'b0 || d1_out_ctrl !== 6'b000001 || d1_out_data[31:0] !== 32'hBEEF)
            begin tests_failed++; $display("FAIL bubble_drain1: got v=%0b ctrl=%06b d=%h want v=0 ctrl=000001 d=beef", d1_out_valid, d1_out_ctrl, d1_out_data[31:0]); end
        // Drain from TWO: the skid beat must carry its own ctrl forward.
        out_ready = 1'b0;
        offer(1'b1, 6'h2A, 32'h100); step();
        offer(1'b1, 6'h15, 32'h200); step();
        offer(1'b0, 6'h00, 32'h0);
        tests_run++; if (d1_occ !== 2'd2 || d1_out_ctrl !== 6'h2A)
            begin tests_failed++; $display("FAIL bubble_two: got occ=%0d ctrl=%02h want occ=2 ctrl=2a", d1_occ, d1_out_ctrl); end
        out_ready = 1'b1; step();
        tests_run++; if (d1_out_valid !== 1'b1 || d1_out_ctrl !== 6'h15 || d1_out_data[31:0] !== 32'h200)
            begin tests_failed++; $display("FAIL bubble_skid_pop: got v=%0b ctrl=%02h d=%h want v=1 ctrl=15 d=200", d1_out_valid, d1_out_ctrl, d1_out_data[31:0]); end
        step();
        tests_run++; if (d1_out_valid !== 1'b0 || d1_out_ctrl !== 6'b000001 || d1_out_data[31:0] !== 32'h200)
            begin tests_failed++; $display("FAIL bubble_drain2: got v=%0b ctrl=%06b d=%h want v=0 ctrl=000001 d=200", d1_out_valid, d1_out_ctrl, d1_out_data[31:0]); end
    endtask

    task automatic test_param_sweep();
        logic [255:0] p;
        logic [255:0] q;
        p = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_00A5};
        q = {64'h4444_1111_2222_3333, 64'h3333_1111_2222_3333, 64'h2222_1111_2222_3333, 64'h1111_1111_2222_335A};
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 6'h07; in_data_w = p;
        $display("[TB] offer wide beat P ctrl=07");
        step();
        in_ctrl = 6'h08; in_data_w = q;
        $display("[TB] offer wide beat Q ctrl=08");
        step();
        in_valid = 1'b0; in_ctrl = 6'h00; in_data_w = '0;
        tests_run++; if (d2_occ !== 2'd2 || d2_in_ready !== 1'b0 || d3_occ !== 2'd2 || d3_in_ready !== 1'b0)
            begin tests_failed++; $display("FAIL sweep_two: got d2 occ=%0d rdy=%0b d3 occ=%0d rdy=%0b want 2 0 2 0", d2_occ, d2_in_ready, d3_occ, d3_in_ready); end
        tests_run++; if (d3_out_data !== p || d2_out_data !== 8'hA5)
            begin tests_failed++; $display("FAIL sweep_lanes_p: got d3=%h d2=%h want d3=%h d2=a5", d3_out_data, d2_out_data, p); end
        tests_run++; if (d3_out_data[192 +: 64] !== 64'hDDDD_0000_0000_0004)
            begin tests_failed++; $display("FAIL sweep_lane3: got %h want dddd000000000004", d3_out_data[192 +: 64]); end
        out_ready = 1'b1; step();
        tests_run++; if (d3_out_data !== q || d2_out_data !== 8'h5A || d3_out_ctrl !== 6'h08 || d2_occ !== 2'd1)
            begin tests_failed++; $display("FAIL sweep_lanes_q: got d3=%h d2=%h ctrl=%02h occ=%0d want d3=%h d2=5a ctrl=08 occ=1", d3_out_data, d2_out_data, d3_out_ctrl, d2_occ, q); end
        step();
        tests_run++; if (d3_out_valid !== 1'b0 || d2_out_valid !== 1'b0 || d3_out_data !== q)
            begin tests_failed++; $display("FAIL sweep_drain: got v3=%0b v2=%0b d3=%h want 0 0 %h", d3_out_valid, d2_out_valid, d3_out_data, q); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        offer(1'b1, 6'h11, 32'h55); step();
        offer(1'b1, 6'h12, 32'h66); step();
        offer(1'b0, 6'h00, 32'h0);
        tests_run++; if (d0_occ !== 2'd2)
            begin tests_failed++; $display("FAIL rst_fill: got occ=%0d want 2", d0_occ); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (d0_out_valid !== 1'b0 || d0_out_ctrl !== 6'h00 || d0_out_data !== 96'd0)
            begin tests_failed++; $display("FAIL rst_async_out: got v=%0b ctrl=%02h d=%h want 0 00 0", d0_out_valid, d0_out_ctrl, d0_out_data); end
        tests_run++; if (d0_occ !== 2'd0 || d0_in_ready !== 1'b1 || d3_occ !== 2'd0)
            begin tests_failed++; $display("FAIL rst_async_state: got occ=%0d rdy=%0b occ3=%0d want 0 1 0", d0_occ, d0_in_ready, d3_occ); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (d0_out_valid !== 1'b0 || d0_occ !== 2'd0)
                begin tests_failed++; $display("FAIL rst_no_emit[%0d]: got v=%0b occ=%0d want 0 0", i, d0_out_valid, d0_occ); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble_ctrl();
        test_param_sweep();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
